// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   Parametrised, pipelined carry-lookahead adder/subtractor. Each of the
//   STAGES pipeline segments adds SEG = WIDTH/STAGES bits using chained
//   BLOCK-bit lookahead groups. The carry between segments is registered.
//   Results already produced are forwarded unchanged, and operand bits not
//   yet consumed are forwarded to later segments. Flow control is a global
//   stall.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand set present
//   in_ready   block accepts operands this cycle
//   X, Y       operands A and B
//   C_in       carry in (add mode only)
//   sub        0 = X+Y+C_in, 1 = X-Y
//   out_valid  result present
//   out_ready  consumer accepts result this cycle
//   Z          sum/difference
//   C_out      carry out of MSB (sub mode: 1 = no borrow)
//   overflow   two's-complement signed overflow
//   zero       Z == 0 (low while out_valid = 0)
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             C_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             C_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SEG    = WIDTH / STAGES;
    localparam int unsigned GROUPS = SEG / BLOCK;

    // One segment: lookahead inside each group, ripple between groups.
    // Returns {carry into segment MSB, carry out, sum}.
    function automatic logic [SEG+1:0] seg_add(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           cc;
        logic           pp;
        int unsigned    base;
        int unsigned    j;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int unsigned grp = 0; grp < GROUPS; grp++) begin
            base = grp * BLOCK;
            for (int unsigned i = 0; i < BLOCK; i++) begin
                // Expanded generate/propagate terms referenced only to the
                // group carry-in, so no carry ripples inside a group.
                cc = 1'b0;
                pp = 1'b1;
                for (int unsigned m = 0; m <= i; m++) begin
                    j  = base + i - m;
                    cc = cc | (pp & g[j]);
                    pp = pp & p[j];
                end
                c[base+i+1] = cc | (pp & c[base]);
            end
        end
        return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] z_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] z_d [STAGES];
    logic             c_d [STAGES];
    logic             ovf_d;

    logic [WIDTH-1:0] eff_y;
    logic             eff_cin;
    logic [SEG+1:0]   r;
    logic             adv;

    assign out_valid = v_q[STAGES-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv & rst_n;
    assign Z         = z_q[STAGES-1];
    assign C_out     = c_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = out_valid & (Z == '0);

    always_comb begin
        // Subtraction is folded into the operands once, at stage 0 capture.
        eff_y   = sub ? ~Y : Y;
        eff_cin = sub | C_in;

        r        = seg_add(X[SEG-1:0], eff_y[SEG-1:0], eff_cin);
        a_d[0]   = X;
        b_d[0]   = eff_y;
        z_d[0]   = '0;
        z_d[0][SEG-1:0] = r[SEG-1:0];
        c_d[0]   = r[SEG];
        ovf_d    = r[SEG+1] ^ r[SEG];

        for (int unsigned k = 1; k < STAGES; k++) begin
            r      = seg_add(a_q[k-1][k*SEG +: SEG], b_q[k-1][k*SEG +: SEG], c_q[k-1]);
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            z_d[k] = z_q[k-1];
            z_d[k][k*SEG +: SEG] = r[SEG-1:0];
            c_d[k] = r[SEG];
            // The last iteration leaves the final segment's overflow here.
            ovf_d  = r[SEG+1] ^ r[SEG];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                z_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                z_q[k] <= z_d[k];
                c_q[k] <= c_d[k];
            end
            v_q[0] <= in_valid;
            for (int unsigned k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         C_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;

    logic         in_ready, out_valid, C_out, overflow, zero;
    logic [W-1:0] Z;
    logic         in_ready1, out_valid1, C_out1, overflow1, zero1;
    logic [W-1:0] Z1;
    logic         in_ready8, out_valid8, C_out8, overflow8, zero8;
    logic [W-1:0] Z8;

    int errors = 0;
    int checks = 0;
    logic [W+2:0] exp_q [$];

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .C_in(C_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .Z(Z), .C_out(C_out), .overflow(overflow), .zero(zero)
    );

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .X(X), .Y(Y), .C_in(C_in), .sub(sub), .out_valid(out_valid1),
        .out_ready(out_ready), .Z(Z1), .C_out(C_out1), .overflow(overflow1), .zero(zero1)
    );

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .X(X), .Y(Y), .C_in(C_in), .sub(sub), .out_valid(out_valid8),
        .out_ready(out_ready), .Z(Z8), .C_out(C_out8), .overflow(overflow8), .zero(zero8)
    );

    // Reference: plain modular and signed integer arithmetic.
    // Packed as {zero, overflow, carry, Z}.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic cin, input logic s);
        logic [W:0]   full;
        logic [W-1:0] z;
        logic         cy;
        logic         ov;
        longint       sx;
        longint       sy;
        longint       res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            z   = x - y;
            cy  = (x >= y);
            res = sx - sy;
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
            z    = full[W-1:0];
            cy   = full[W];
            res  = sx + sy + longint'(cin);
        end
        ov = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        return {(z == '0), ov, cy, z};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if ({zero, overflow, C_out, Z} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {zero, overflow, C_out, Z});
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_latency;
        int lat2 = 0, lat1 = 0, lat8 = 0;
        logic [W+2:0] g2, g1, g8, e;
        g2 = '0; g1 = '0; g8 = '0;
        out_ready = 1'b1;
        X = 32'hFFFF_FFFF; Y = 32'h0000_0001; C_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        e = model(X, Y, C_in, sub);
        checks++;
        if ({in_ready, in_ready1, in_ready8} !== 3'b111) begin
            errors++; $display("FAIL latency_in_ready got=%b exp=111", {in_ready, in_ready1, in_ready8});
        end
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (out_valid  && lat2 == 0) begin lat2 = n; g2 = {zero, overflow, C_out, Z}; end
            if (out_valid1 && lat1 == 0) begin lat1 = n; g1 = {zero1, overflow1, C_out1, Z1}; end
            if (out_valid8 && lat8 == 0) begin lat8 = n; g8 = {zero8, overflow8, C_out8, Z8}; end
            tick();
        end
        checks++;
        if (lat2 != 2) begin errors++; $display("FAIL latency_stages2 got=%0d exp=2", lat2); end
        checks++;
        if (lat1 != 1) begin errors++; $display("FAIL latency_stages1 got=%0d exp=1", lat1); end
        checks++;
        if (lat8 != 8) begin errors++; $display("FAIL latency_stages8 got=%0d exp=8", lat8); end
        checks++;
        if (g2 !== e) begin errors++; $display("FAIL wrap_stages2 got=%h exp=%h", g2, e); end
        checks++;
        if (g1 !== e) begin errors++; $display("FAIL wrap_stages1 got=%h exp=%h", g1, e); end
        checks++;
        if (g8 !== e) begin errors++; $display("FAIL wrap_stages8 got=%h exp=%h", g8, e); end
    endtask

    task automatic test_directed;
        logic [W-1:0] tx [7] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_FFFF, 32'd5, 32'h8000_0000, 32'd5, 32'h8000_0000};
        logic [W-1:0] ty [7] = '{32'h1, 32'h1, 32'h0, 32'd7, 32'h1, 32'd7, 32'h1};
        logic         tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         ts [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        // {zero, overflow, C_out, Z}
        logic [W+2:0] te [7] = '{
            {1'b1, 1'b0, 1'b1, 32'h0000_0000},
            {1'b0, 1'b1, 1'b0, 32'h8000_0000},
            {1'b0, 1'b0, 1'b0, 32'h0001_0000},
            {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE},
            {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF},
            {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE},
            {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF}};
        int lat;
        out_ready = 1'b1;
        for (int t = 0; t < 7; t++) begin
            X = tx[t]; Y = ty[t]; C_in = tc[t]; sub = ts[t]; in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL directed_in_ready case=%0d got=%b exp=1", t, in_ready); end
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            checks++;
            if (lat != 2) begin errors++; $display("FAIL directed_latency case=%0d got=%0d exp=2", t, lat); end
            checks++;
            if ({zero, overflow, C_out, Z} !== te[t]) begin
                errors++;
                $display("FAIL directed_result case=%0d got=%h exp=%h", t, {zero, overflow, C_out, Z}, te[t]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        int first = -1, last = -1, nvalid = 0;
        logic [W+2:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc < 8) begin
                in_valid = 1'b1;
                X = $urandom; Y = $urandom;
                C_in = 1'($urandom_range(0, 1));
                sub  = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                nvalid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected_result cyc=%0d got=%h exp=none", cyc, Z);
                end else begin
                    e = exp_q.pop_front();
                    if ({zero, overflow, C_out, Z} !== e) begin
                        errors++;
                        $display("FAIL b2b_result cyc=%0d got=%h exp=%h", cyc, {zero, overflow, C_out, Z}, e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(X, Y, C_in, sub));
            tick();
        end
        checks++;
        if (first != 2) begin errors++; $display("FAIL b2b_first_valid got=%0d exp=2", first); end
        checks++;
        if (nvalid != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", nvalid); end
        checks++;
        if (last - first != 7) begin errors++; $display("FAIL b2b_contiguous got=%0d exp=7", last - first); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        int npush = 0, npop = 0;
        logic [W+2:0] held, got;
        held = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (cyc <= 7);
            X = $urandom; Y = $urandom;
            C_in = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            #1;
            got = {zero, overflow, C_out, Z};
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_unexpected_result cyc=%0d got=%h exp=none", cyc, got);
                end else if (got !== exp_q[0]) begin
                    errors++; $display("FAIL bp_result cyc=%0d got=%h exp=%h", cyc, got, exp_q[0]);
                end
                if (out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    npop++;
                end
            end
            if (cyc >= 3 && cyc <= 6) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                if (cyc == 3) begin
                    held = got;
                    checks++;
                    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
                end else begin
                    checks++;
                    if (got !== held) begin errors++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, got, held); end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(X, Y, C_in, sub));
                npush++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (npush != 4) begin errors++; $display("FAIL bp_accepted got=%0d exp=4", npush); end
        checks++;
        if (npop != npush) begin errors++; $display("FAIL bp_drained got=%0d exp=%0d", npop, npush); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            X = $urandom; Y = $urandom; C_in = 1'b0; sub = 1'b0;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_accept op=%0d got=%b exp=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (Z !== '0) begin errors++; $display("FAIL rst_mid_z got=%h exp=0", Z); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready_held got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release got=%b exp=1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({out_valid, out_valid1, out_valid8} !== 3'b000) begin
                errors++; $display("FAIL rst_mid_stale cyc=%0d got=%b exp=000", i, {out_valid, out_valid1, out_valid8});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
